// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU sequencer. Contains the opcode
//            constants, the flag bit positions of the {Z,C,F,N,L} register,
//            the sequencer state encoding, the writeback class enum and the
//            opcode-to-class decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  // Register index width for the 16-entry register file.
  localparam int c_reg_idx_w = 4;

  // Two-operand opcodes. 0x01..0x09 form one contiguous register-writing range.
  localparam logic [7:0] c_op_and  = 8'h01;
  localparam logic [7:0] c_op_or   = 8'h02;
  localparam logic [7:0] c_op_xor  = 8'h03;
  localparam logic [7:0] c_op_not  = 8'h04;
  localparam logic [7:0] c_op_add  = 8'h05;
  localparam logic [7:0] c_op_addu = 8'h06;
  localparam logic [7:0] c_op_addc = 8'h07;
  localparam logic [7:0] c_op_sub  = 8'h08;
  localparam logic [7:0] c_op_subc = 8'h09;
  localparam logic [7:0] c_op_cmp  = 8'h0B;
  localparam logic [7:0] c_op_cmpu = 8'h0F;

  // High nibbles of opcode families whose low nibble carries an immediate,
  // plus the shift family.
  localparam logic [3:0] c_op_hi_imm5  = 4'h5;
  localparam logic [3:0] c_op_hi_imm6  = 4'h6;
  localparam logic [3:0] c_op_hi_imm7  = 4'h7;
  localparam logic [3:0] c_op_hi_shift = 4'h8;

  // Bit positions inside the {Z,C,F,N,L} flag vector.
  localparam int c_flag_z = 4;
  localparam int c_flag_c = 3;
  localparam int c_flag_f = 2;
  localparam int c_flag_n = 1;
  localparam int c_flag_l = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    WB_NOP   = 2'd0,
    WB_WRITE = 2'd1,
    WB_FLAGS = 2'd2
  } wb_class_e;

  // Maps an opcode to what the writeback stage is allowed to update.
  function automatic wb_class_e decode_wb_class(input logic [7:0] op);
    wb_class_e cls;
    cls = WB_NOP;
    if (op >= c_op_and && op <= c_op_subc) begin
      cls = WB_WRITE;
    end else if (op[7:4] == c_op_hi_imm5 || op[7:4] == c_op_hi_imm6 ||
                 op[7:4] == c_op_hi_imm7 || op[7:4] == c_op_hi_shift) begin
      cls = WB_WRITE;
    end else if (op == c_op_cmp || op == c_op_cmpu) begin
      cls = WB_FLAGS;
    end
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_regfile.sv
//------------------------------------------------------------------------------
// Module   : alu_seq_regfile
// Purpose  : General register file, REG_COUNT x DATA_WIDTH, one synchronous
//            write port and three combinational read ports (A, B, debug).
//            Synchronous reset clears every entry.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            we, waddr, wdata     - write port
//            raddr_a / rdata_a    - operand A read port
//            raddr_b / rdata_b    - operand B read port
//            raddr_dbg / rdata_dbg- debug read port
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_seq_regfile
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [c_reg_idx_w-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic [c_reg_idx_w-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0]  rdata_a,
  input  logic [c_reg_idx_w-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0]  rdata_b,
  input  logic [c_reg_idx_w-1:0] raddr_dbg,
  output logic [DATA_WIDTH-1:0]  rdata_dbg
);

  logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] mem_d [REG_COUNT];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the registered contents only, so a write becomes visible the
  // cycle after its edge.
  assign rdata_a   = mem_q[raddr_a];
  assign rdata_b   = mem_q[raddr_b];
  assign rdata_dbg = mem_q[raddr_dbg];

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : alu_sequencer
// Purpose  : Multi-cycle controller owning the register file and the {Z,C,F,N,L}
//            flag register. Accepts one instruction per valid/ready handshake,
//            drives an external combinational ALU from registered operands,
//            captures result and flags, then writes back according to the
//            opcode class. Sequence: IDLE -> EXEC -> WB -> IDLE.
// Ports    : clk, reset                         - clock, sync active-high reset
//            req_valid/req_ready/req_opcode/
//            req_rdest/req_rsrc                 - instruction request
//            alu_a/alu_b/alu_opcode/alu_cin     - registered ALU drive
//            alu_c/alu_flags                    - ALU response
//            done_valid/done_result             - completion, one WB cycle
//            flags                              - architectural flag register
//            dbg_addr/dbg_data                  - combinational register peek
//            retire_count                       - only with ALU_SEQ_RETIRE_CNT_EN
// Config   : `define ALU_SEQ_RETIRE_CNT_EN adds a 16-bit retire counter output
//            counting WRITE and FLAGS_ONLY completions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_opcode,
  input  logic [c_reg_idx_w-1:0] req_rdest,
  input  logic [c_reg_idx_w-1:0] req_rsrc,
  output logic [DATA_WIDTH-1:0]  alu_a,
  output logic [DATA_WIDTH-1:0]  alu_b,
  output logic [7:0]             alu_opcode,
  output logic                   alu_cin,
  input  logic [DATA_WIDTH-1:0]  alu_c,
  input  logic [4:0]             alu_flags,
  output logic                   done_valid,
  output logic [DATA_WIDTH-1:0]  done_result,
  output logic [4:0]             flags,
  input  logic [c_reg_idx_w-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]  dbg_data
`ifdef ALU_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]            retire_count
`endif
);

  seq_state_e             state_q,     state_d;
  wb_class_e              cls_q,       cls_d;
  logic [DATA_WIDTH-1:0]  a_q,         a_d;
  logic [DATA_WIDTH-1:0]  b_q,         b_d;
  logic [7:0]             opcode_q,    opcode_d;
  logic [c_reg_idx_w-1:0] rdest_q,     rdest_d;
  logic [DATA_WIDTH-1:0]  result_q,    result_d;
  logic [4:0]             stflags_q,   stflags_d;
  logic [4:0]             flags_q,     flags_d;
  logic                   done_valid_q, done_valid_d;
  logic                   ready_q,     ready_d;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0]            retire_q,    retire_d;
`endif

  logic                   rf_we;
  logic [DATA_WIDTH-1:0]  rf_rdata_a;
  logic [DATA_WIDTH-1:0]  rf_rdata_b;

  alu_seq_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we        (rf_we),
    .waddr     (rdest_q),
    .wdata     (result_q),
    .raddr_a   (req_rdest),
    .rdata_a   (rf_rdata_a),
    .raddr_b   (req_rsrc),
    .rdata_b   (rf_rdata_b),
    .raddr_dbg (dbg_addr),
    .rdata_dbg (dbg_data)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    a_d       = a_q;
    b_d       = b_q;
    opcode_d  = opcode_q;
    rdest_d   = rdest_q;
    result_d  = result_q;
    stflags_d = stflags_q;
    flags_d   = flags_q;
    rf_we     = 1'b0;
`ifdef ALU_SEQ_RETIRE_CNT_EN
    retire_d  = retire_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d      = rf_rdata_a;
          b_d      = rf_rdata_b;
          opcode_d = req_opcode;
          rdest_d  = req_rdest;
          cls_d    = decode_wb_class(req_opcode);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // NOPs report a zero result regardless of what the ALU produced.
        result_d  = (cls_q == WB_NOP) ? '0 : alu_c;
        stflags_d = alu_flags;
        state_d   = ST_WB;
      end
      ST_WB: begin
        if (cls_q != WB_NOP) begin
          flags_d = stflags_q;
`ifdef ALU_SEQ_RETIRE_CNT_EN
          retire_d = retire_q + 16'd1;
`endif
        end
        rf_we   = (cls_q == WB_WRITE);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    done_valid_d = (state_d == ST_WB);
    ready_d      = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cls_q        <= WB_NOP;
      a_q          <= '0;
      b_q          <= '0;
      opcode_q     <= '0;
      rdest_q      <= '0;
      result_q     <= '0;
      stflags_q    <= '0;
      flags_q      <= '0;
      done_valid_q <= 1'b0;
      ready_q      <= 1'b1;
`ifdef ALU_SEQ_RETIRE_CNT_EN
      retire_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      a_q          <= a_d;
      b_q          <= b_d;
      opcode_q     <= opcode_d;
      rdest_q      <= rdest_d;
      result_q     <= result_d;
      stflags_q    <= stflags_d;
      flags_q      <= flags_d;
      done_valid_q <= done_valid_d;
      ready_q      <= ready_d;
`ifdef ALU_SEQ_RETIRE_CNT_EN
      retire_q     <= retire_d;
`endif
    end
  end

  assign req_ready   = ready_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_opcode  = opcode_q;
  // Flags only move at the WB edge, so the carry-in is stable for all of EXEC.
  assign alu_cin     = flags_q[c_flag_c];
  assign done_valid  = done_valid_q;
  assign done_result = result_q;
  assign flags       = flags_q;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  assign retire_count = retire_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_sequencer
// Purpose  : Directed self-checking bench for alu_sequencer. A small ALU stub
//            answers the sequencer: ADD/ADDC/CMP behave as real arithmetic,
//            0x5x shifts its low nibble into operand A (used to preload
//            registers), every other opcode returns a non-zero junk pattern.
// Config   : honours ALU_SEQ_RETIRE_CNT_EN (connects and checks retire_count).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_opcode;
  logic [3:0]  req_rdest;
  logic [3:0]  req_rsrc;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_opcode;
  logic        alu_cin;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;
  logic        done_valid;
  logic [15:0] done_result;
  logic [4:0]  flags;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_count;
`endif

  int n_checks    = 0;
  int n_errors    = 0;
  int exp_retired = 0;

  always #5 clk = ~clk;

  alu_sequencer #(
    .DATA_WIDTH (16),
    .REG_COUNT  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_rdest    (req_rdest),
    .req_rsrc     (req_rsrc),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_cin      (alu_cin),
    .alu_c        (alu_c),
    .alu_flags    (alu_flags),
    .done_valid   (done_valid),
    .done_result  (done_result),
    .flags        (flags),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    .retire_count (retire_count)
`endif
  );

  // ALU stub, flags packed {Z,C,F,N,L}.
  logic [16:0] sum;
  always_comb begin
    sum       = '0;
    alu_c     = 16'hDEAD;
    alu_flags = 5'b11111;
    if (alu_opcode == 8'h05 || alu_opcode == 8'h07) begin
      sum = {1'b0, alu_a} + {1'b0, alu_b} +
            {16'd0, (alu_opcode == 8'h07) ? alu_cin : 1'b0};
      alu_c     = sum[15:0];
      alu_flags = {1'b0, sum[16],
                   (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]),
                   1'b0, 1'b0};
    end else if (alu_opcode == 8'h0B) begin
      alu_c     = 16'h0000;
      alu_flags = {alu_a == alu_b, 1'b0, 1'b0,
                   $signed(alu_b) > $signed(alu_a), alu_b > alu_a};
    end else if (alu_opcode[7:4] == 4'h5) begin
      alu_c     = {alu_a[11:0], alu_opcode[3:0]};
      alu_flags = 5'b00000;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input logic [3:0] idx, input logic [15:0] exp);
    dbg_addr = idx;
    #1;
    check($sformatf("R%0d", idx), {16'd0, dbg_data}, {16'd0, exp});
  endtask

  task automatic check_retire();
`ifdef ALU_SEQ_RETIRE_CNT_EN
    check("retire_count", {16'd0, retire_count}, exp_retired);
`endif
  endtask

  // Issues one instruction from a negedge and follows it through EXEC, WB and
  // back to IDLE, returning at the negedge of the IDLE cycle.
  task automatic run_op(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [15:0] exp_a, input logic [15:0] exp_b,
                        input logic [15:0] exp_res, input logic exp_cin,
                        input logic retires);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_issue", {31'd0, req_ready}, 1);
    req_valid  = 1'b1;
    req_opcode = op;
    req_rdest  = rd;
    req_rsrc   = rs;
    @(negedge clk);
    req_valid = 1'b0;
    check("exec_ready",  {31'd0, req_ready},  0);
    check("exec_done",   {31'd0, done_valid}, 0);
    check("alu_a",       {16'd0, alu_a},      {16'd0, exp_a});
    check("alu_b",       {16'd0, alu_b},      {16'd0, exp_b});
    check("alu_opcode",  {24'd0, alu_opcode}, {24'd0, op});
    check("alu_cin",     {31'd0, alu_cin},    {31'd0, exp_cin});
    @(negedge clk);
    check("wb_done",     {31'd0, done_valid}, 1);
    check("wb_result",   {16'd0, done_result}, {16'd0, exp_res});
    check("wb_ready",    {31'd0, req_ready},  0);
    @(negedge clk);
    check("idle_done",   {31'd0, done_valid}, 0);
    check("idle_ready",  {31'd0, req_ready},  1);
    if (retires) exp_retired++;
  endtask

  // Builds a value in a freshly cleared register with four nibble loads.
  task automatic load_reg(input logic [3:0] rd, input logic [15:0] val);
    logic [15:0] prev;
    logic [15:0] nxt;
    logic [3:0]  nib;
    prev = 16'h0000;
    for (int i = 3; i >= 0; i--) begin
      nib = val[i*4 +: 4];
      nxt = {prev[11:0], nib};
      run_op({4'h5, nib}, rd, rd, prev, prev, nxt, 1'b0, 1'b1);
      prev = nxt;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_opcode = 8'h00;
    req_rdest  = 4'd0;
    req_rsrc   = 4'd0;
    dbg_addr   = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_ready",      {31'd0, req_ready},  1);
    check("rst_done",       {31'd0, done_valid}, 0);
    check("rst_flags",      {27'd0, flags},      0);
    check("rst_alu_a",      {16'd0, alu_a},      0);
    check("rst_alu_b",      {16'd0, alu_b},      0);
    check("rst_alu_opcode", {24'd0, alu_opcode}, 0);
    check("rst_result",     {16'd0, done_result}, 0);
    check_reg(4'd0,  16'h0000);
    check_reg(4'd15, 16'h0000);
    check_retire();

    // ADD with signed overflow: 0x7FFF + 0x0001
    load_reg(4'd1, 16'h7FFF);
    load_reg(4'd2, 16'h0001);
    run_op(8'h05, 4'd1, 4'd2, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    check_reg(4'd1, 16'h8000);
    check_reg(4'd2, 16'h0001);
    check("add_flags", {27'd0, flags}, {27'd0, 5'b00100});

    // ADD producing carry, then ADDC consuming it
    load_reg(4'd5, 16'hFFFF);
    load_reg(4'd6, 16'h0001);
    load_reg(4'd7, 16'h1234);
    load_reg(4'd8, 16'h0001);
    run_op(8'h05, 4'd5, 4'd6, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1);
    check_reg(4'd5, 16'h0000);
    check("carry_flags", {27'd0, flags}, {27'd0, 5'b01000});
    run_op(8'h07, 4'd7, 4'd8, 16'h1234, 16'h0001, 16'h1236, 1'b1, 1'b1);
    check_reg(4'd7, 16'h1236);
    check("addc_flags", {27'd0, flags}, {27'd0, 5'b00000});

    // CMP leaves the register file untouched
    load_reg(4'd3, 16'h0002);
    load_reg(4'd4, 16'h0005);
    run_op(8'h0B, 4'd3, 4'd4, 16'h0002, 16'h0005, 16'h0000, 1'b0, 1'b1);
    check_reg(4'd3, 16'h0002);
    check("cmp_flags", {27'd0, flags}, {27'd0, 5'b00011});

    // NOP: ALU stub returns junk, nothing may change, result reads zero
    run_op(8'hA0, 4'd3, 4'd4, 16'h0002, 16'h0005, 16'h0000, 1'b0, 1'b0);
    check_reg(4'd3, 16'h0002);
    check("nop_flags", {27'd0, flags}, {27'd0, 5'b00011});

    // rdest == rsrc
    run_op(8'h05, 4'd2, 4'd2, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b1);
    check_reg(4'd2, 16'h0002);
    check("same_reg_flags", {27'd0, flags}, {27'd0, 5'b00000});
    check_retire();

    // Reset asserted while an instruction is in EXEC
    req_valid  = 1'b1;
    req_opcode = 8'h05;
    req_rdest  = 4'd1;
    req_rsrc   = 4'd2;
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_exec_ready", {31'd0, req_ready}, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_retired = 0;
    check("midrst_ready",  {31'd0, req_ready},  1);
    check("midrst_done",   {31'd0, done_valid}, 0);
    check("midrst_flags",  {27'd0, flags},      0);
    check("midrst_alu_a",  {16'd0, alu_a},      0);
    check("midrst_opcode", {24'd0, alu_opcode}, 0);
    check("midrst_result", {16'd0, done_result}, 0);
    check_reg(4'd1, 16'h0000);
    check_reg(4'd7, 16'h0000);
    @(negedge clk);
    check("midrst_done_later", {31'd0, done_valid}, 0);
    check_reg(4'd1, 16'h0000);
    check_retire();

    // req_valid held high: accepts on every third edge, each reading the
    // value the previous instruction just wrote.
    req_valid  = 1'b1;
    req_opcode = 8'h51;
    req_rdest  = 4'd9;
    req_rsrc   = 4'd9;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("hold_ready_%0d", k), {31'd0, req_ready},  (k % 3 == 2) ? 1 : 0);
      check($sformatf("hold_done_%0d", k),  {31'd0, done_valid}, (k % 3 == 1) ? 1 : 0);
      if (k == 3) check("raw_alu_a_1", {16'd0, alu_a}, 32'h0001);
      if (k == 6) check("raw_alu_a_2", {16'd0, alu_a}, 32'h0011);
    end
    req_valid = 1'b0;
    exp_retired += 3;
    check_reg(4'd9, 16'h0111);
    check_retire();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
